// File: rtl/uart_frame_bit_counter.sv
// uart_frame_bit_counter: per-channel UART frame sequencer (START, DATA, optional PARITY, STOP) at bit-period granularity.
// Latency: all outputs registered; phase/bit_idx/busy/frame_done/frame_cnt move one cycle after the qualifying start/step/clear.
// Backpressure: none; start is ignored while busy, step is ignored in IDLE. Optional PARITY phase: define UART_BCNT_PARITY_EN.
module uart_frame_bit_counter #(
  parameter int NUM_CH        = 2,
  parameter int MAX_DATA_BITS = 8,
  parameter int FRAME_CNT_W   = 16,
  localparam int IDX_W        = $clog2(MAX_DATA_BITS),
  localparam int DB_W         = $clog2(MAX_DATA_BITS + 1)
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic [NUM_CH-1:0]               start_i,
  input  logic [NUM_CH-1:0]               step_i,
  input  logic [NUM_CH-1:0]               clear_i,
  input  logic [DB_W-1:0]                 data_bits_i,
  input  logic                            parity_en_i,
  input  logic                            stop2_i,
  output logic [3*NUM_CH-1:0]             phase_o,
  output logic [IDX_W*NUM_CH-1:0]         bit_idx_o,
  output logic [NUM_CH-1:0]               busy_o,
  output logic [NUM_CH-1:0]               frame_done_o,
  output logic [FRAME_CNT_W*NUM_CH-1:0]   frame_cnt_o
);

  // Phase encodings are visible on phase_o, so they are fixed values.
  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_START  = 3'd1;
  localparam logic [2:0] PH_DATA   = 3'd2;
`ifdef UART_BCNT_PARITY_EN
  localparam logic [2:0] PH_PARITY = 3'd3;
`endif
  localparam logic [2:0] PH_STOP   = 3'd4;

  // Legal data length window and the 8N1 length restored on reset.
  localparam logic [DB_W-1:0] DB_MIN = DB_W'(5);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(MAX_DATA_BITS);
  localparam logic [DB_W-1:0] DB_RST = DB_W'((MAX_DATA_BITS < 8) ? MAX_DATA_BITS : 8);

  logic [DB_W-1:0] db_clamped;

`ifndef UART_BCNT_PARITY_EN
  // Parity is not built in this configuration; the input is intentionally left unconsumed.
  logic unused_parity_en;
  assign unused_parity_en = parity_en_i;
`endif

  // Clamp the shared data length once; every channel latches this value on an accepted start.
  always_comb begin
    db_clamped = data_bits_i;
    if (data_bits_i < DB_MIN) begin
      db_clamped = DB_MIN;
    end else if (data_bits_i > DB_MAX) begin
      db_clamped = DB_MAX;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [2:0]             phase_q, phase_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DB_W-1:0]        db_q, db_d;
    logic                   stop2_q, stop2_d;
`ifdef UART_BCNT_PARITY_EN
    logic                   par_q, par_d;
`endif
    logic                   done_q, done_d;
    logic                   busy_q;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   more_data;

    // Another data bit follows when the next index is still inside the latched length.
    assign more_data = (DB_W'(idx_q) + DB_W'(1)) < db_q;

    // Frame sequencing: clear wins over start/step; start only lands in IDLE, step only moves a busy channel.
    always_comb begin
      phase_d = phase_q;
      idx_d   = idx_q;
      db_d    = db_q;
      stop2_d = stop2_q;
`ifdef UART_BCNT_PARITY_EN
      par_d   = par_q;
`endif
      done_d  = 1'b0;
      cnt_d   = cnt_q;

      if (clear_i[c]) begin
        phase_d = PH_IDLE;
        idx_d   = '0;
      end else begin
        case (phase_q)
          PH_IDLE: begin
            if (start_i[c]) begin
              phase_d = PH_START;
              idx_d   = '0;
              db_d    = db_clamped;
              stop2_d = stop2_i;
`ifdef UART_BCNT_PARITY_EN
              par_d   = parity_en_i;
`endif
            end
          end
          PH_START: begin
            if (step_i[c]) begin
              phase_d = PH_DATA;
              idx_d   = '0;
            end
          end
          PH_DATA: begin
            if (step_i[c]) begin
              if (more_data) begin
                idx_d = idx_q + IDX_W'(1);
              end
`ifdef UART_BCNT_PARITY_EN
              else if (par_q) begin
                phase_d = PH_PARITY;
                idx_d   = '0;
              end
`endif
              else begin
                phase_d = PH_STOP;
                idx_d   = '0;
              end
            end
          end
`ifdef UART_BCNT_PARITY_EN
          PH_PARITY: begin
            if (step_i[c]) begin
              phase_d = PH_STOP;
              idx_d   = '0;
            end
          end
`endif
          PH_STOP: begin
            if (step_i[c]) begin
              if (stop2_q && (idx_q == '0)) begin
                idx_d = IDX_W'(1);
              end else begin
                phase_d = PH_IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
                cnt_d   = cnt_q + FRAME_CNT_W'(1);
              end
            end
          end
          default: begin
            phase_d = PH_IDLE;
            idx_d   = '0;
          end
        endcase
      end
    end

    // State registers; reset returns the channel to IDLE with the 8N1 configuration latched.
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        phase_q <= PH_IDLE;
        idx_q   <= '0;
        db_q    <= DB_RST;
        stop2_q <= 1'b0;
`ifdef UART_BCNT_PARITY_EN
        par_q   <= 1'b0;
`endif
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        phase_q <= phase_d;
        idx_q   <= idx_d;
        db_q    <= db_d;
        stop2_q <= stop2_d;
`ifdef UART_BCNT_PARITY_EN
        par_q   <= par_d;
`endif
        done_q  <= done_d;
        busy_q  <= (phase_d != PH_IDLE);
        cnt_q   <= cnt_d;
      end
    end

    assign phase_o[c*3 +: 3]                     = phase_q;
    assign bit_idx_o[c*IDX_W +: IDX_W]           = idx_q;
    assign busy_o[c]                             = busy_q;
    assign frame_done_o[c]                       = done_q;
    assign frame_cnt_o[c*FRAME_CNT_W +: FRAME_CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_uart_frame_bit_counter.sv
// tb_uart_frame_bit_counter: scoreboard bench; a frame-position model predicts every output cycle.
// Latency: expected values are queued at the input edge and checked 1 time unit after the following posedge.
// Backpressure: not applicable; directed scenarios followed by randomized start/step/clear/reset/config traffic.
module tb_uart_frame_bit_counter;
  localparam int NUM_CH = 2;
  localparam int MAXDB  = 8;
  localparam int FCW    = 3;
  localparam int IDX_W  = $clog2(MAXDB);
  localparam int DB_W   = $clog2(MAXDB + 1);

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  logic [NUM_CH-1:0] start_i = '0, step_i = '0, clear_i = '0;
  logic [DB_W-1:0] data_bits_i = '0;
  logic parity_en_i = 1'b0, stop2_i = 1'b0;
  logic [3*NUM_CH-1:0] phase_o;
  logic [IDX_W*NUM_CH-1:0] bit_idx_o;
  logic [NUM_CH-1:0] busy_o, frame_done_o;
  logic [FCW*NUM_CH-1:0] frame_cnt_o;

  always #5 clk = ~clk;

  uart_frame_bit_counter #(.NUM_CH(NUM_CH), .MAX_DATA_BITS(MAXDB), .FRAME_CNT_W(FCW)) dut (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .step_i(step_i), .clear_i(clear_i),
    .data_bits_i(data_bits_i), .parity_en_i(parity_en_i), .stop2_i(stop2_i),
    .phase_o(phase_o), .bit_idx_o(bit_idx_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o));

  // Reference model: a frame is a run of steps; position within it decides phase and index.
  typedef struct {
    bit active; int pos; int db; bit par; bit s2; int cnt; bit done;
  } ch_m_t;
  ch_m_t m[NUM_CH];

  typedef struct packed {
    logic [3*NUM_CH-1:0]     ph;
    logic [IDX_W*NUM_CH-1:0] ix;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic [FCW*NUM_CH-1:0]   cnt;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0, fails = 0;
  int cfg_db = 8;
  bit cfg_par = 0, cfg_s2 = 0;

  function automatic int clampdb(int v);
    if (v < 5) return 5;
    if (v > MAXDB) return MAXDB;
    return v;
  endfunction

  function automatic int total_steps(ch_m_t c);
    return 1 + c.db + (c.par ? 1 : 0) + (c.s2 ? 2 : 1);
  endfunction

  function automatic void model_step(int c, logic r, logic s, logic st, logic cl);
    m[c].done = 0;
    if (r) begin
      m[c].active = 0; m[c].pos = 0; m[c].cnt = 0; m[c].db = 8; m[c].par = 0; m[c].s2 = 0;
    end else if (cl) begin
      m[c].active = 0;
    end else if (!m[c].active) begin
      if (s) begin
        m[c].active = 1;
        m[c].pos = 0;
        m[c].db = clampdb(cfg_db);
`ifdef UART_BCNT_PARITY_EN
        m[c].par = cfg_par;
`else
        m[c].par = 0;
`endif
        m[c].s2 = cfg_s2;
      end
    end else if (st) begin
      m[c].pos++;
      if (m[c].pos == total_steps(m[c])) begin
        m[c].active = 0;
        m[c].done = 1;
        m[c].cnt = (m[c].cnt + 1) % (1 << FCW);
      end
    end
  endfunction

  function automatic void view(ch_m_t c, output logic [2:0] ph, output logic [IDX_W-1:0] ix);
    ph = 3'd0; ix = '0;
    if (!c.active) begin
      ph = 3'd0;
    end else if (c.pos == 0) begin
      ph = 3'd1;
    end else if (c.pos <= c.db) begin
      ph = 3'd2; ix = IDX_W'(c.pos - 1);
    end else if (c.par && c.pos == c.db + 1) begin
      ph = 3'd3;
    end else begin
      ph = 3'd4; ix = IDX_W'(c.pos - 1 - c.db - (c.par ? 1 : 0));
    end
  endfunction

  // One input cycle: drive at negedge, advance the model, queue the outputs expected after the next posedge.
  task automatic cyc(input logic r, input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] st,
                     input logic [NUM_CH-1:0] cl);
    exp_t e;
    logic [2:0] ph;
    logic [IDX_W-1:0] ix;
    @(negedge clk);
    reset_i = r; start_i = s; step_i = st; clear_i = cl;
    data_bits_i = DB_W'(cfg_db); parity_en_i = cfg_par; stop2_i = cfg_s2;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      model_step(c, r, s[c], st[c], cl[c]);
      view(m[c], ph, ix);
      e.ph[c*3 +: 3] = ph;
      e.ix[c*IDX_W +: IDX_W] = ix;
      e.busy[c] = m[c].active;
      e.done[c] = m[c].done;
      e.cnt[c*FCW +: FCW] = FCW'(m[c].cnt);
    end
    exp_q.push_back(e);
  endtask

  task automatic steps(input logic [NUM_CH-1:0] ch, input int n);
    repeat (n) cyc(1'b0, '0, ch, '0);
  endtask

  task automatic set_cfg(input int db, input bit par, input bit s2);
    cfg_db = db; cfg_par = par; cfg_s2 = s2;
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s ch%0d @%0t: got %0h expected %0h", nm, c, $time, act, expv);
    end
  endtask

  // Monitor: outputs are presented every cycle, so each posedge retires one queued expectation.
  exp_t me;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      for (int c = 0; c < NUM_CH; c++) begin
        chk("phase",      c, 32'(phase_o[c*3 +: 3]),              32'(me.ph[c*3 +: 3]));
        chk("bit_idx",    c, 32'(bit_idx_o[c*IDX_W +: IDX_W]),    32'(me.ix[c*IDX_W +: IDX_W]));
        chk("busy",       c, 32'(busy_o[c]),                      32'(me.busy[c]));
        chk("frame_done", c, 32'(frame_done_o[c]),                32'(me.done[c]));
        chk("frame_cnt",  c, 32'(frame_cnt_o[c*FCW +: FCW]),      32'(me.cnt[c*FCW +: FCW]));
      end
    end
  end

  initial begin
    logic r;
    logic [NUM_CH-1:0] s, st, cl;
    for (int c = 0; c < NUM_CH; c++) m[c] = '{0, 0, 8, 0, 0, 0, 0};

    cyc(1'b1, '0, '0, '0);
    cyc(1'b1, '0, '0, '0);
    cyc(1'b0, '0, '0, '0);

    // 8N1 on ch0, ch1 idle throughout
    set_cfg(8, 0, 0);
    cyc(1'b0, 2'b01, '0, '0);
    steps(2'b01, 10);
    cyc(1'b0, '0, '0, '0);

    // 8E2 on ch1
    set_cfg(8, 1, 1);
    cyc(1'b0, 2'b10, '0, '0);
    steps(2'b10, 12);
    cyc(1'b0, '0, '0, '0);

    // data length clamping, low and high
    set_cfg(3, 0, 0);
    cyc(1'b0, 2'b01, '0, '0);
    steps(2'b01, 7);
    set_cfg(15, 0, 0);
    cyc(1'b0, 2'b01, '0, '0);
    steps(2'b01, 10);

    // clear at DATA idx 4, then clear racing the final STOP step
    set_cfg(8, 0, 0);
    cyc(1'b0, 2'b01, '0, '0);
    steps(2'b01, 5);
    cyc(1'b0, '0, '0, 2'b01);
    cyc(1'b0, '0, '0, '0);
    cyc(1'b0, 2'b01, '0, '0);
    steps(2'b01, 9);
    cyc(1'b0, '0, 2'b01, 2'b01);
    cyc(1'b0, '0, '0, '0);

    // back-to-back frames; a mid-frame start with another config is ignored
    cyc(1'b0, 2'b01, '0, '0);
    steps(2'b01, 10);
    cyc(1'b0, 2'b01, '0, '0);
    steps(2'b01, 3);
    set_cfg(5, 1, 1);
    cyc(1'b0, 2'b01, 2'b01, '0);
    steps(2'b01, 6);
    cyc(1'b0, '0, '0, '0);

    // start and step together in IDLE: the step is not counted
    set_cfg(8, 0, 0);
    cyc(1'b0, 2'b11, 2'b11, '0);
    steps(2'b11, 10);

    // counter wrap: nine short 5N1 frames on ch0
    set_cfg(5, 0, 0);
    repeat (9) begin
      cyc(1'b0, 2'b01, '0, '0);
      steps(2'b01, 7);
    end

    // reset mid-frame
    cyc(1'b0, 2'b11, '0, '0);
    steps(2'b11, 4);
    cyc(1'b1, '0, '0, '0);
    cyc(1'b0, '0, '0, '0);

    // randomized traffic with config churn mid-frame
    repeat (3000) begin
      set_cfg($urandom_range(0, 15), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      r = ($urandom_range(0, 1499) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        s[c]  = ($urandom_range(0, 3) == 0);
        st[c] = 1'($urandom_range(0, 1));
        cl[c] = ($urandom_range(0, 79) == 0);
      end
      cyc(r, s, st, cl);
    end
    cyc(1'b0, '0, '0, '0);

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_frame_bit_counter.md
# uart_frame_bit_counter

Parametrised multi-channel UART frame sequencer that replaces the fixed 8-bit TX/RX bit counters. Each channel tracks its position within a serial frame (start, data, optional parity, stop) at bit-period granularity, with runtime-selectable data length and stop bits. It reports the current phase and bit index, and raises a one-cycle frame-done pulse. It sits between the baud tick generator and the TX/RX controller FSMs; channel 0 is TX and channel 1 is RX by default.

## Interface
- NUM_CH, 2, number of independent channels.
- MAX_DATA_BITS, 8, largest supported data length (≥5).
- FRAME_CNT_W, 16, width of the per-channel completed-frame counter.
- Derived: IDX_W = $clog2(MAX_DATA_BITS); DB_W = $clog2(MAX_DATA_BITS+1).
- clock  in  1  single clock; all logic is posedge.
- reset  in  1  synchronous, active-high; all channels go to IDLE.
- start  in  NUM_CH  per-channel frame-start request; honoured only in IDLE.
- step  in  NUM_CH  per-channel end-of-bit-period tick from the baud generator.
- clear  in  NUM_CH  per-channel synchronous abort to IDLE.
- data_bits  in  DB_W  shared data length; sampled per channel on accepted start.
- parity_en  in  1  shared; parity bit present; sampled on start.
- stop2  in  1  shared; two stop bits when 1, else one; sampled on start.
- phase  out  3*NUM_CH  per-channel phase: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
- bit_idx  out  IDX_W*NUM_CH  per-channel index within DATA or STOP; 0 elsewhere.
- busy  out  NUM_CH  per-channel; 1 when phase≠IDLE.
- frame_done  out  NUM_CH  per-channel one-cycle pulse on frame completion.
- frame_cnt  out  FRAME_CNT_W*NUM_CH  per-channel count of completed frames.

## Operation
- Channels are fully independent and share only the configuration inputs.
- Per-channel FSM, evaluated each cycle, with priority reset > clear > start/step:
  - IDLE: start → START; latch the config and set bit_idx=0. step is ignored.
  - START: step → DATA, idx 0.
  - DATA: on step, go to idx+1 if idx < latched data_bits−1. Otherwise go to PARITY if the latched parity_en is set, else to STOP idx 0.
  - PARITY: step → STOP, idx 0.
  - STOP: on step, go to idx 1 if stop2 is latched and idx=0. Otherwise go to IDLE, pulse frame_done and increment frame_cnt.
- data_bits clamping at latch time: values below 5 become 5; values above MAX_DATA_BITS become MAX_DATA_BITS.
- start while busy is ignored; there is no restart and the latched config is unchanged.
- Simultaneous start and step in IDLE: the channel enters START, and that step is not counted.
- clear: the channel goes to IDLE with bit_idx=0. There is no frame_done and frame_cnt is unchanged. clear beats a simultaneous final step.
- frame_cnt wraps from 2^FRAME_CNT_W−1 to 0.
- Changing the config inputs mid-frame has no effect on an in-flight frame.

## Timing
- All outputs are registered. phase, bit_idx and busy update in the cycle after the qualifying start or step edge.
- frame_done is high for exactly one cycle, coincident with phase first reading IDLE. frame_cnt increments in that same cycle.
- Steps per frame = 1 + data_bits + parity + stops. Examples: 8N1 takes 10 steps, 8E2 takes 12.
- Back-to-back frames: start may be asserted in the frame_done cycle and is accepted. There are zero dead cycles.
- Reset values: phase=0, bit_idx=0, busy=0, frame_done=0, frame_cnt=0, latched config = 8N1. Reset mid-frame aborts the frame with no frame_done.

## Configuration
- UART_BCNT_PARITY_EN defined: the PARITY phase is implemented and parity_en is honoured.
- UART_BCNT_PARITY_EN undefined:
  - parity_en is ignored and the PARITY state is not synthesised.
  - DATA goes directly to STOP.
  - phase never reads 3.

## Test plan
- Reset, then start ch0 with data_bits=8, parity_en=0, stop2=0, then 10 steps. Expect the phase sequence 1,2×8 (idx 0–7),4, then 0 with frame_done=1 for one cycle and frame_cnt[0]=1. ch1 stays IDLE.
- Configure 8E2 on ch1 with UART_BCNT_PARITY_EN defined, then 12 steps. Expect phase 3 after the 9th step, STOP idx 0 then 1, and frame_done after the 12th step. Without the macro, frame_done comes after the 11th step.
- Start with data_bits=3 gives a 7-step frame (clamped to 5). Start with data_bits=15 gives 8 data steps.
- Assert clear at DATA idx 4; expect phase=0 the next cycle, no frame_done, frame_cnt unchanged. Assert clear together with the final STOP step; expect no frame_done.
- Assert start in the frame_done cycle, then run 10 more steps. Expect a second frame_done and frame_cnt=2. A start issued mid-frame is ignored.
- Set FRAME_CNT_W=2 and run 5 frames; expect frame_cnt 1,2,3,0,1. Assert reset mid-frame; expect all outputs to be 0 the next cycle.
